// File: rtl/lane_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : lane_accumulator
// Purpose  : Two-stage add/accumulate pipeline. Stage 1 adds the two
//            lane-masked operands plus the negate carry-in. Stage 2 either
//            passes that sum through (SUM), adds it into a running
//            accumulator (ACC), or clears the accumulator (CLR).
//            Valid/ready handshakes are used on both the input and output sides.
// Options  : ACC_SATURATE_EN - when defined, ACC results that overflow as
//            signed values clamp to the signed limits and set a sticky sat
//            flag. When undefined, ACC wraps modulo 2^32 and sat is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module lane_accumulator (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] y1,
    input  logic [31:0] y2,
    input  logic        neg,
    input  logic [1:0]  acc_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        carry,
    output logic        ovf,
    output logic        zero,
    output logic        sat
);

    localparam logic [1:0] c_OP_ACC = 2'b01;
    localparam logic [1:0] c_OP_CLR = 2'b10;

    // Stage 1 registers
    logic        r_s1_valid;
    logic [31:0] r_s1_sum;
    logic        r_s1_c;
    logic        r_s1_ovf;
    logic [1:0]  r_s1_op;

    // Stage 2 registers (these drive the outputs)
    logic        r_s2_valid;
    logic [31:0] r_acc;
    logic [31:0] r_result;
    logic        r_carry;
    logic        r_ovf;
    logic        r_zero;

    // Handshake and datapath wires
    logic        w_advance;
    logic        w_s1_load;
    logic        w_s2_take;
    logic [32:0] w_s1_sum33;
    logic        w_s1_ovf;
    logic [32:0] w_acc_sum33;
    logic        w_acc_ovf;
    logic [31:0] w_acc_val;
    logic [31:0] w_nxt_result;
    logic        w_nxt_carry;
    logic        w_nxt_ovf;
    logic [31:0] w_nxt_acc;

    // Stage 2 may take a new entry whenever it is empty or its output is
    // being consumed. Stage 1 may load whenever it is empty or it is itself
    // about to move into stage 2.
    assign w_advance = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_advance;
    assign w_s2_take = w_advance && r_s1_valid;
    assign in_ready  = w_s1_load;

    // Stage 1 add: same-sign operands that produce a differently-signed sum
    // have overflowed. The carry-in cannot change that rule.
    assign w_s1_sum33 = {1'b0, y1} + {1'b0, y2} + {32'd0, neg};
    assign w_s1_ovf   = (y1[31] == y2[31]) && (w_s1_sum33[31] != y1[31]);

    // Stage 1 register: captures an offered operand pair whenever it can load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_sum   <= 32'd0;
            r_s1_c     <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_op    <= 2'b00;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_sum <= w_s1_sum33[31:0];
                r_s1_c   <= w_s1_sum33[32];
                r_s1_ovf <= w_s1_ovf;
                r_s1_op  <= acc_op;
            end
        end
    end

    // Accumulate add. The accumulator register is always current for the
    // entry in stage 1 because it is written only on transfer into stage 2,
    // so back-to-back ACC operations need no bubble.
    assign w_acc_sum33 = {1'b0, r_acc} + {1'b0, r_s1_sum};
    assign w_acc_ovf   = (r_acc[31] == r_s1_sum[31]) && (w_acc_sum33[31] != r_acc[31]);

`ifdef ACC_SATURATE_EN
    logic r_sat;
    logic w_nxt_sat;

    // Clamp toward the sign of the operands: a negative accumulator can only
    // overflow downward, and a positive one can only overflow upward.
    always_comb begin
        w_acc_val = w_acc_sum33[31:0];
        if (w_acc_ovf) begin
            w_acc_val = r_acc[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
    end

    // Sticky saturation: set by a clamping ACC, cleared only by CLR.
    always_comb begin
        w_nxt_sat = r_sat;
        if (r_s1_op == c_OP_ACC) begin
            w_nxt_sat = r_sat | w_acc_ovf;
        end else if (r_s1_op == c_OP_CLR) begin
            w_nxt_sat = 1'b0;
        end
    end

    // Sat flag register: updated together with the rest of stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_s2_take) begin
            r_sat <= w_nxt_sat;
        end
    end

    assign sat = r_sat;
`else
    assign w_acc_val = w_acc_sum33[31:0];
    assign sat       = 1'b0;
`endif

    // Stage 2 operation select. The reserved encoding behaves as SUM.
    always_comb begin
        w_nxt_result = r_s1_sum;
        w_nxt_carry  = r_s1_c;
        w_nxt_ovf    = r_s1_ovf;
        w_nxt_acc    = r_acc;
        case (r_s1_op)
            c_OP_ACC: begin
                w_nxt_result = w_acc_val;
                w_nxt_carry  = w_acc_sum33[32];
                w_nxt_ovf    = w_acc_ovf;
                w_nxt_acc    = w_acc_val;
            end
            c_OP_CLR: begin
                w_nxt_result = 32'd0;
                w_nxt_carry  = 1'b0;
                w_nxt_ovf    = 1'b0;
                w_nxt_acc    = 32'd0;
            end
            default: begin
                w_nxt_result = r_s1_sum;
            end
        endcase
    end

    // Stage 2 register: the outputs hold while stalled. When stage 2 drains
    // without a replacement, valid drops and the old result is left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_acc      <= 32'd0;
            r_result   <= 32'd0;
            r_carry    <= 1'b0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b1;
        end else if (w_advance) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_acc    <= w_nxt_acc;
                r_result <= w_nxt_result;
                r_carry  <= w_nxt_carry;
                r_ovf    <= w_nxt_ovf;
                r_zero   <= (w_nxt_result == 32'd0);
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
`default_nettype wire

// File: doc/lane_accumulator.md
LANE_ACCUMULATOR -- requirements
Module: lane_accumulator

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-003 SHALL have port in_valid, input, 1, operand pair offered.
REQ-004 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-005 SHALL have port y1, input, 32, first lane-masked operand from the copier stage.
REQ-006 SHALL have port y2, input, 32, second lane-masked operand from the copier stage.
REQ-007 SHALL have port neg, input, 1, carry-in; the copier's negate flag.
REQ-008 SHALL have port acc_op, input, 2, operation: 00 SUM, 01 ACC, 10 CLR, 11 reserved (treated as SUM).
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port result, output, 32, operation result.
REQ-012 SHALL have port carry, output, 1, unsigned carry-out of the final add.
REQ-013 SHALL have port ovf, output, 1, signed overflow of the final add.
REQ-014 SHALL have port zero, output, 1, result == 0.
REQ-015 SHALL have port sat, output, 1, sticky saturation flag (see Configuration).

Function
REQ-016 SHALL be a two-stage pipeline (S1 add, S2 accumulate), each stage with its own valid bit; latency in_valid&in_ready to out_valid is exactly 2 cycles with no backpressure.
REQ-017 SHALL compute in S1 the 33-bit sum {c1,s1} = y1 + y2 + neg, registering s1, c1, S1 signed overflow, and acc_op.
REQ-018 SHALL drive in_ready = !s1_valid | (!s2_valid | out_ready); both stages advance together when S2 is empty or out_ready is high.
REQ-019 SHALL, for SUM, deliver result = s1, carry = c1, ovf = S1 overflow; the accumulator is unchanged.
REQ-020 SHALL, for ACC, compute acc_next = acc + s1 (32-bit), load acc with acc_next, and deliver result = acc_next, carry = carry-out of that add, ovf = signed overflow of that add.
REQ-021 SHALL, for CLR, load acc with 0 and deliver result = 0, carry = 0, ovf = 0.
REQ-022 SHALL update acc only when an S1 entry transfers into S2 (exactly once per accepted ACC/CLR, never on stall).
REQ-023 SHALL hold result, carry, ovf, zero and out_valid stable while out_valid & !out_ready.
REQ-024 SHALL use the acc value produced by the immediately preceding ACC/CLR for back-to-back ACC operations (no hazard bubble, full throughput).
REQ-025 SHALL drop out_valid to 0 after the handshake when no new entry advances into S2.
REQ-026 SHALL ignore y1, y2, neg and acc_op when in_valid is 0.

Reset
REQ-027 SHALL, with rst high at a clock edge, clear s1_valid, s2_valid, acc, result, carry, ovf, sat to 0 and set zero to 1.
REQ-028 SHALL discard in-flight entries on reset mid-operation; in_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, with ACC_SATURATE_EN defined, clamp a signed-overflowing ACC result to 32'h7FFFFFFF (positive overflow) or 32'h80000000 (negative), load that value into acc, report ovf = 1, and set sat, which clears only on CLR or reset.
REQ-030 SHALL, without ACC_SATURATE_EN, wrap the ACC result modulo 2^32 and tie sat to 0; SUM is never saturated in either build.

Verification
REQ-031 SHALL cover SUM: y1=32'hFFFFFFFF, y2=0, neg=1 -> 2 cycles later result=0, carry=1, zero=1, ovf=0.
REQ-032 SHALL cover ACC streaming: after CLR, ACC with y1=5,y2=0 three back-to-back cycles with out_ready=1 -> results 5, 10, 15 on consecutive cycles.
REQ-033 SHALL cover backpressure: out_ready=0 for 4 cycles with 3 ops offered -> in_ready falls after two accepted, result held, acc updated exactly twice, no loss on release.
REQ-034 SHALL cover overflow: acc=32'h7FFFFFFF, ACC with y1=1 -> ACC_SATURATE_EN: result=32'h7FFFFFFF, ovf=1, sat=1; otherwise result=32'h80000000, ovf=1, sat=0.
REQ-035 SHALL cover reset mid-operation: rst pulsed with both stages valid -> next cycle out_valid=0, result=0, acc=0, in_ready=1.
